apb_cfg_master: RTL

//  APB initiator that turns a simple valid/ready command stream into APB transfers.

---
 rtl/apb_cfg_pkg.sv | 21 ++
 rtl/apb_cfg_master.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/apb_cfg_pkg.sv
// Shared types and constants for the APB configuration master.
//   state_t        : controller state (IDLE, SETUP, ACCESS, RESP)
//   APB_DATA_WIDTH : data width of the coefficient/bypass register map
//   tmo_cnt_width  : bits needed to count up to a given timeout value
package apb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned APB_DATA_WIDTH = 32;

    // Width of a counter that must be able to hold timeout_cycles itself.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_cfg_master.sv
// APB initiator: converts a valid/ready command stream into single APB
// transfers and returns one response per command through a valid/ready
// response handshake. One transfer outstanding at a time.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req_*/o_req_ready command stream (write flag, address, write data)
//   o_rsp_*/i_rsp_ready response stream (read data, timeout error)
//   o_p*/i_p*           APB requester signals
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES wait cycles with PREADY low (response flagged o_rsp_err).
// Without it ACCESS waits indefinitely and o_rsp_err is constant 0.
module apb_cfg_master
    import apb_cfg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic                  i_pready,
    input  logic [DATA_WIDTH-1:0] i_prdata
);

    // Reject parameter sets the register map cannot support.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32 || DATA_WIDTH != APB_DATA_WIDTH ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_cfg_master: unsupported parameter set");
    end

    state_t state;
    state_t state_d;

    logic                  accept_c;
    logic                  timeout_c;
    logic                  req_ready_d;
    logic                  rsp_valid_d;
    logic                  rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  psel_d;
    logic                  penable_d;
    logic                  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;

    assign accept_c = i_req_valid && o_req_ready;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts ACCESS cycles spent waiting on PREADY; restarted every SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !i_pready && !timeout_c) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // PREADY in the same cycle takes priority over the abort.
    assign timeout_c = (state == ACCESS) && !i_pready &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_paddr     <= '0;
            o_pwdata    <= '0;
        end else begin
            state       <= state_d;
            o_req_ready <= req_ready_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_err   <= rsp_err_d;
            o_rsp_rdata <= rsp_rdata_d;
            o_psel      <= psel_d;
            o_penable   <= penable_d;
            o_pwrite    <= pwrite_d;
            o_paddr     <= paddr_d;
            o_pwdata    <= pwdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept_c)               state_d = SETUP;
            SETUP:                               state_d = ACCESS;
            ACCESS:  if (i_pready || timeout_c)  state_d = RESP;
            RESP:    if (i_rsp_ready)            state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output next values: phase flags follow the upcoming state so the
    // registered outputs line up with it; payload fields hold unless loaded.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = o_rsp_err;
        rsp_rdata_d = o_rsp_rdata;
        pwrite_d    = o_pwrite;
        paddr_d     = o_paddr;
        pwdata_d    = o_pwdata;

        if (state == IDLE && accept_c) begin
            pwrite_d = i_req_write;
            paddr_d  = i_req_addr;
            pwdata_d = i_req_wdata;
        end

        // Completion or abort: read data only for a successful read.
        if (state == ACCESS && state_d == RESP) begin
            rsp_err_d   = timeout_c;
            rsp_rdata_d = (i_pready && !o_pwrite) ? i_prdata : '0;
        end
    end

endmodule
